// File: rtl/iicmb_seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : iicmb_seq_pkg
// Purpose : Shared definitions for the IICMB transaction sequencer: register
//           map, CMDR command codes, CMDR status bit positions, completion
//           codes and the sequencer state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package iicmb_seq_pkg;

  // Controller register map (Wishbone byte registers)
  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;
  localparam logic [1:0] ADR_FSMR = 2'd3;

  // CMDR command codes
  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_READ_ACK = 8'h02;
  localparam logic [7:0] CMD_READ_NAK = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h04;
  localparam logic [7:0] CMD_STOP     = 8'h05;
  localparam logic [7:0] CMD_SET_BUS  = 8'h06;

  // CSR values: core enable + interrupt enable, and full disable
  localparam logic [7:0] CSR_ENABLE  = 8'hC0;
  localparam logic [7:0] CSR_DISABLE = 8'h00;

  // CMDR status bit positions
  localparam int STS_DON = 7;
  localparam int STS_NAK = 6;
  localparam int STS_AL  = 5;
  localparam int STS_ERR = 4;

  typedef enum logic [1:0] {
    SEQ_OK       = 2'd0,
    SEQ_NAK      = 2'd1,
    SEQ_ARB_LOST = 2'd2,
    SEQ_ERR      = 2'd3
  } seq_status_t;

  typedef enum logic [4:0] {
    ST_IDLE       = 5'd0,
    ST_ENABLE     = 5'd1,
    ST_BUS_CHK    = 5'd2,
    ST_BUS_DPR    = 5'd3,
    ST_BUS_CMD    = 5'd4,
    ST_START      = 5'd5,
    ST_ADDR_DPR   = 5'd6,
    ST_ADDR_CMD   = 5'd7,
    ST_DATA       = 5'd8,
    ST_WDATA_WAIT = 5'd9,
    ST_WDATA_DPR  = 5'd10,
    ST_WDATA_CMD  = 5'd11,
    ST_RDATA_CMD  = 5'd12,
    ST_RDATA_DPR  = 5'd13,
    ST_STOP       = 5'd14,
    ST_CW_IRQ     = 5'd15,
    ST_CW_READ    = 5'd16,
    ST_ABORT      = 5'd17,
    ST_DONE       = 5'd18
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/iicmb_wb_access.sv
//------------------------------------------------------------------------------
// Module  : iicmb_wb_access
// Purpose : Single-transfer Wishbone master. A start pulse while not busy
//           launches one access; controls are held until ack_i, dropped on
//           the following edge, and done_o pulses with the captured rdata_o.
// Ports   : clk_i, rst_i            clock, synchronous active-high reset
//           start_i/we_i/adr_i/wdata_i  access request
//           busy_o/done_o/rdata_o   status and read data
//           cyc_o/stb_o/we_o/adr_o/dat_o/dat_i/ack_i  Wishbone master port
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iicmb_wb_access (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  logic       cyc_q;
  logic       we_q;
  logic [1:0] adr_q;
  logic [7:0] dat_q;
  logic       done_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (ack_i) begin
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          adr_q   <= '0;
          dat_q   <= '0;
          done_q  <= 1'b1;
          rdata_q <= dat_i;
        end
      end else if (start_i && !done_q) begin
        // The done cycle is forced idle, guaranteeing a gap between accesses
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdata_i;
      end
    end
  end

  assign busy_o  = cyc_q | done_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign we_o    = we_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;

endmodule

`default_nettype wire

// File: rtl/iicmb_txn_sequencer.sv
//------------------------------------------------------------------------------
// Module  : iicmb_txn_sequencer
// Purpose : Converts one I2C request (bus, address, op, length, byte stream)
//           into the IICMB register command sequence over Wishbone, waits on
//           irq for each command, decodes CMDR status and reports completion.
// Ports   : clk_i, rst_i            clock, synchronous active-high reset
//           req_*                   request handshake and fields
//           wdata_valid/wdata/wdata_ready  write byte stream
//           rdata_valid/rdata       read byte pulses
//           done/status             completion pulse and code
//           cyc_o..ack_i            Wishbone master port, irq_i interrupt
// Options : IICMB_SEQ_TIMEOUT_EN - abort any command wait after
//           TIMEOUT_CYCLES cycles, disabling the core (status ERR).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iicmb_txn_sequencer
  import iicmb_seq_pkg::*;
#(
  parameter int NUM_BUSSES     = 1,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_bus,
  input  logic [6:0]       req_addr,
  input  logic             req_op,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wdata_valid,
  input  logic [7:0]       wdata,
  output logic             wdata_ready,
  output logic             rdata_valid,
  output logic [7:0]       rdata,
  output logic             done,
  output logic [1:0]       status,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [1:0]       adr_o,
  output logic [7:0]       dat_o,
  input  logic [7:0]       dat_i,
  input  logic             ack_i,
  input  logic             irq_i
);

  seq_state_t       state_q, state_d;
  seq_state_t       ret_q, ret_d;      // command whose completion CW awaits
  seq_status_t      status_q, status_d;
  logic [3:0]       bus_q, bus_d;
  logic [6:0]       addr_q, addr_d;
  logic             op_q, op_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       wbyte_q, wbyte_d;
  logic             core_en_q, core_en_d;
  logic             bus_valid_q, bus_valid_d;
  logic [3:0]       cache_bus_q, cache_bus_d;
  logic             rdv_q, rdv_d;
  logic [7:0]       rdata_q, rdata_d;

  logic       wb_access, wb_we, wb_busy, wb_done;
  logic [1:0] wb_adr;
  logic [7:0] wb_wdata, wb_rdata;
  logic       w_timeout;
  logic       w_wdata_ready;

  iicmb_wb_access u_wb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (wb_access & ~wb_busy),
    .we_i    (wb_we),
    .adr_i   (wb_adr),
    .wdata_i (wb_wdata),
    .busy_o  (wb_busy),
    .done_o  (wb_done),
    .rdata_o (wb_rdata),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .dat_i   (dat_i),
    .ack_i   (ack_i)
  );

`ifdef IICMB_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Counts consecutive cycles spent waiting for irq; cleared outside CW
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_CW_IRQ) to_cnt_q <= '0;
    else                               to_cnt_q <= to_cnt_q + TO_W'(1);
  end
  assign w_timeout = (state_q == ST_CW_IRQ) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  assign req_ready     = (state_q == ST_IDLE) & ~rst_i;
  assign w_wdata_ready = (state_q == ST_WDATA_WAIT) & wdata_valid & ~rst_i;
  assign wdata_ready   = w_wdata_ready;
  assign done          = (state_q == ST_DONE) & ~rst_i;
  assign status        = done ? status_q : SEQ_OK;
  assign rdata_valid   = rdv_q;
  assign rdata         = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      status_q    <= SEQ_OK;
      bus_q       <= '0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      rem_q       <= '0;
      wbyte_q     <= '0;
      core_en_q   <= 1'b0;
      bus_valid_q <= 1'b0;
      cache_bus_q <= '0;
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      status_q    <= status_d;
      bus_q       <= bus_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      wbyte_q     <= wbyte_d;
      core_en_q   <= core_en_d;
      bus_valid_q <= bus_valid_d;
      cache_bus_q <= cache_bus_d;
      rdv_q       <= rdv_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    status_d    = status_q;
    bus_d       = bus_q;
    addr_d      = addr_q;
    op_d        = op_q;
    rem_d       = rem_q;
    wbyte_d     = wbyte_q;
    core_en_d   = core_en_q;
    bus_valid_d = bus_valid_q;
    cache_bus_d = cache_bus_q;
    rdv_d       = 1'b0;
    rdata_d     = rdata_q;
    wb_access   = 1'b0;
    wb_we       = 1'b0;
    wb_adr      = ADR_CSR;
    wb_wdata    = 8'h00;

    case (state_q)
      ST_IDLE: if (req_valid) begin
        bus_d    = req_bus;
        addr_d   = req_addr;
        op_d     = req_op;
        rem_d    = req_len;
        status_d = SEQ_OK;
        if ({1'b0, req_bus} >= 5'(NUM_BUSSES)) begin
          status_d = SEQ_ERR;
          state_d  = ST_DONE;
        end else if (!core_en_q) state_d = ST_ENABLE;
        else                     state_d = ST_BUS_CHK;
      end
      ST_ENABLE: begin
        wb_access = 1'b1; wb_we = 1'b1; wb_adr = ADR_CSR; wb_wdata = CSR_ENABLE;
        if (wb_done) begin core_en_d = 1'b1; state_d = ST_BUS_CHK; end
      end
      ST_BUS_CHK: state_d = (bus_valid_q && cache_bus_q == bus_q) ? ST_START : ST_BUS_DPR;
      ST_BUS_DPR: begin
        wb_access = 1'b1; wb_we = 1'b1; wb_adr = ADR_DPR; wb_wdata = {4'h0, bus_q};
        if (wb_done) state_d = ST_BUS_CMD;
      end
      ST_BUS_CMD, ST_START, ST_ADDR_CMD, ST_WDATA_CMD, ST_RDATA_CMD, ST_STOP: begin
        wb_access = 1'b1; wb_we = 1'b1; wb_adr = ADR_CMDR;
        case (state_q)
          ST_BUS_CMD:   wb_wdata = CMD_SET_BUS;
          ST_START:     wb_wdata = CMD_START;
          ST_RDATA_CMD: wb_wdata = (rem_q == LEN_W'(1)) ? CMD_READ_NAK : CMD_READ_ACK;
          ST_STOP:      wb_wdata = CMD_STOP;
          default:      wb_wdata = CMD_WRITE;
        endcase
        if (wb_done) begin ret_d = state_q; state_d = ST_CW_IRQ; end
      end
      ST_ADDR_DPR: begin
        wb_access = 1'b1; wb_we = 1'b1; wb_adr = ADR_DPR; wb_wdata = {addr_q, op_q};
        if (wb_done) state_d = ST_ADDR_CMD;
      end
      ST_DATA: begin
        if (rem_q == '0) state_d = ST_STOP;
        else if (op_q)   state_d = ST_RDATA_CMD;
        else             state_d = ST_WDATA_WAIT;
      end
      ST_WDATA_WAIT: if (w_wdata_ready) begin
        wbyte_d = wdata;
        state_d = ST_WDATA_DPR;
      end
      ST_WDATA_DPR: begin
        wb_access = 1'b1; wb_we = 1'b1; wb_adr = ADR_DPR; wb_wdata = wbyte_q;
        if (wb_done) state_d = ST_WDATA_CMD;
      end
      ST_RDATA_DPR: begin
        wb_access = 1'b1; wb_adr = ADR_DPR;
        if (wb_done) begin
          rdv_d   = 1'b1;
          rdata_d = wb_rdata;
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
          state_d = ST_DATA;
        end
      end
      ST_CW_IRQ: begin
        if (irq_i)          state_d = ST_CW_READ;
        else if (w_timeout) state_d = ST_ABORT;
      end
      ST_CW_READ: begin
        // Reading CMDR both fetches status and clears the interrupt
        wb_access = 1'b1; wb_adr = ADR_CMDR;
        if (wb_done) begin
          if (wb_rdata[STS_AL]) begin
            status_d = SEQ_ARB_LOST; bus_valid_d = 1'b0; state_d = ST_DONE;
          end else if (wb_rdata[STS_ERR]) begin
            status_d = SEQ_ERR; core_en_d = 1'b0; bus_valid_d = 1'b0; state_d = ST_DONE;
          end else if (wb_rdata[STS_NAK] && (ret_q == ST_ADDR_CMD || ret_q == ST_WDATA_CMD)) begin
            status_d = SEQ_NAK; state_d = ST_STOP;
          end else begin
            case (ret_q)
              ST_BUS_CMD: begin
                bus_valid_d = 1'b1; cache_bus_d = bus_q; state_d = ST_START;
              end
              ST_START:     state_d = ST_ADDR_DPR;
              ST_ADDR_CMD:  state_d = ST_DATA;
              ST_WDATA_CMD: begin
                if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
                state_d = ST_DATA;
              end
              ST_RDATA_CMD: state_d = ST_RDATA_DPR;
              default:      state_d = ST_DONE;
            endcase
          end
        end
      end
      ST_ABORT: begin
        wb_access = 1'b1; wb_we = 1'b1; wb_adr = ADR_CSR; wb_wdata = CSR_DISABLE;
        if (wb_done) begin
          core_en_d = 1'b0; bus_valid_d = 1'b0; status_d = SEQ_ERR; state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_iicmb_txn_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_iicmb_txn_sequencer
// Purpose : Directed self-checking bench for iicmb_txn_sequencer with a
//           behavioural IICMB register model (one slave at address 0x22).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_iicmb_txn_sequencer;

`ifdef IICMB_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 50;
`else
  localparam int TB_TIMEOUT = 100000;
`endif
  localparam logic [6:0] SLAVE = 7'h22;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid, req_ready, req_op;
  logic [3:0] req_bus;
  logic [6:0] req_addr;
  logic [7:0] req_len;
  logic       wdata_valid, wdata_ready, rdata_valid, done;
  logic [7:0] wdata, rdata;
  logic [1:0] status;
  logic       cyc_o, stb_o, we_o, ack_i, irq_i;
  logic [1:0] adr_o;
  logic [7:0] dat_o, dat_i;

  always #5 clk_i = ~clk_i;

  iicmb_txn_sequencer #(.NUM_BUSSES(1), .LEN_W(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus),
    .req_addr(req_addr), .req_op(req_op), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .status(status),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  int errors = 0;
  int checks = 0;

  logic [11:0] wlog[$];      // {00, adr, dat} of every Wishbone write
  logic [11:0] exp_q[$];
  logic [7:0]  slave_wr[$], rd_q[$], wq[$], rcv[$];
  int          wcnt = 0, irq_cnt = 0, done_cnt = 0, wrdy_cnt = 0;
  bit          irq_mute = 1'b0, addr_phase = 1'b0;
  logic [7:0]  dpr_w = 8'h00, dpr_r = 8'h00, resp = 8'h00, force_resp = 8'h00;
  logic [1:0]  last_status = 2'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_nwr"}, wlog.size(), exp_q.size());
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_wr%0d", tag, i), {20'd0, wlog[i]}, {20'd0, exp_q[i]});
  endtask

  // Controller model: ack after two cycles, irq three cycles after a command
  initial begin
    ack_i = 1'b0; dat_i = 8'h00; irq_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (ack_i) begin
        ack_i = 1'b0; dat_i = 8'h00; wcnt = 0;
      end else if (cyc_o && stb_o) begin
        wcnt++;
        if (wcnt >= 2) begin
          ack_i = 1'b1; wcnt = 0;
          if (we_o) begin
            wlog.push_back({2'b00, adr_o, dat_o});
            if (adr_o == 2'd1) dpr_w = dat_o;
            else if (adr_o == 2'd2) begin
              resp = 8'h80;
              case (dat_o)
                8'h04: addr_phase = 1'b1;
                8'h01: begin
                  if (addr_phase) begin
                    addr_phase = 1'b0;
                    if (dpr_w[7:1] != SLAVE) resp = 8'h40;
                  end else slave_wr.push_back(dpr_w);
                end
                8'h02, 8'h03: begin
                  dpr_r = 8'hEE;
                  if (rd_q.size() != 0) dpr_r = rd_q.pop_front();
                end
                default: ;
              endcase
              if (force_resp != 8'h00) begin resp = force_resp; force_resp = 8'h00; end
              irq_cnt = 3;
            end
          end else begin
            if (adr_o == 2'd2) begin dat_i = resp; irq_i = 1'b0; end
            else if (adr_o == 2'd1) dat_i = dpr_r;
          end
        end
      end else wcnt = 0;
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0 && !irq_mute) irq_i = 1'b1;
      end
    end
  end

  // Write-byte source
  initial begin
    wdata_valid = 1'b0; wdata = 8'h00;
    forever begin
      @(negedge clk_i);
      if (wdata_ready) begin
        @(posedge clk_i); #1;
        if (wq.size() != 0) void'(wq.pop_front());
        wrdy_cnt++;
      end
      wdata_valid = (wq.size() != 0);
      wdata       = (wq.size() != 0) ? wq[0] : 8'h00;
    end
  end

  // Completion / read-byte monitor
  initial forever begin
    @(negedge clk_i);
    if (done) begin done_cnt++; last_status = status; end
    if (rdata_valid) rcv.push_back(rdata);
  end

  task automatic issue_req(input logic [3:0] bus, input logic [6:0] addr,
                           input logic op, input logic [7:0] len);
    int t = 0;
    wlog.delete(); rcv.delete(); slave_wr.delete();
    @(negedge clk_i);
    req_bus = bus; req_addr = addr; req_op = op; req_len = len; req_valid = 1'b1;
    while (!req_ready && t < 100) begin @(negedge clk_i); t++; end
    @(posedge clk_i); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [3:0] bus, input logic [6:0] addr,
                         input logic op, input logic [7:0] len);
    int n0;
    int t = 0;
    n0 = done_cnt;
    issue_req(bus, addr, op, len);
    while (done_cnt == n0 && t < 5000) begin @(negedge clk_i); t++; end
    check_eq({tag, "_done"}, done_cnt - n0, 1);
  endtask

  initial begin
    int t;
    int n0;
    rst_i = 1'b1; req_valid = 1'b0; req_bus = '0; req_addr = '0; req_op = 1'b0; req_len = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_cyc", cyc_o, 0);
    check_eq("rst_done", done, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("post_rst_req_ready", req_ready, 1);

    // First write after reset: full enable / set-bus / start sequence
    wq = '{8'h05, 8'h1F};
    run_req("wr1", 4'd0, 7'h22, 1'b0, 8'd2);
    exp_q = '{12'h0C0, 12'h100, 12'h206, 12'h204, 12'h144, 12'h201,
              12'h105, 12'h201, 12'h11F, 12'h201, 12'h205};
    check_log("wr1");
    check_eq("wr1_status", last_status, 0);
    check_eq("wr1_nslave", slave_wr.size(), 2);
    if (slave_wr.size() == 2) begin
      check_eq("wr1_b0", slave_wr[0], 8'h05);
      check_eq("wr1_b1", slave_wr[1], 8'h1F);
    end

    // Read 3 bytes: ACK, ACK, NAK on the last
    rd_q = '{8'hAA, 8'hBB, 8'hCC};
    run_req("rd3", 4'd0, 7'h22, 1'b1, 8'd3);
    exp_q = '{12'h204, 12'h145, 12'h201, 12'h202, 12'h202, 12'h203, 12'h205};
    check_log("rd3");
    check_eq("rd3_status", last_status, 0);
    check_eq("rd3_nrcv", rcv.size(), 3);
    if (rcv.size() == 3) begin
      check_eq("rd3_b0", rcv[0], 8'hAA);
      check_eq("rd3_b1", rcv[1], 8'hBB);
      check_eq("rd3_b2", rcv[2], 8'hCC);
    end

    // Absent slave: address NAK, STOP, no byte consumed
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    n0 = wrdy_cnt;
    run_req("nak", 4'd0, 7'h10, 1'b0, 8'd4);
    exp_q = '{12'h204, 12'h120, 12'h201, 12'h205};
    check_log("nak");
    check_eq("nak_status", last_status, 1);
    check_eq("nak_wrdy", wrdy_cnt - n0, 0);
    wq.delete();

    // Back-to-back writes reuse enable and bus selection
    wq = '{8'hA5};
    run_req("b2b1", 4'd0, 7'h22, 1'b0, 8'd1);
    exp_q = '{12'h204, 12'h144, 12'h201, 12'h1A5, 12'h201, 12'h205};
    check_log("b2b1");
    wq = '{8'h5A};
    run_req("b2b2", 4'd0, 7'h22, 1'b0, 8'd1);
    exp_q = '{12'h204, 12'h144, 12'h201, 12'h15A, 12'h201, 12'h205};
    check_log("b2b2");
    check_eq("b2b2_status", last_status, 0);

    // Out-of-range bus: immediate ERR, no Wishbone traffic
    run_req("oor", 4'd1, 7'h22, 1'b0, 8'd0);
    check_eq("oor_status", last_status, 3);
    check_eq("oor_nwr", wlog.size(), 0);

    // Arbitration lost on START (DON also set; AL wins): no STOP
    force_resp = 8'hA0;
    wq = '{8'h77};
    run_req("al", 4'd0, 7'h22, 1'b0, 8'd1);
    exp_q = '{12'h204};
    check_log("al");
    check_eq("al_status", last_status, 2);
    wq.delete();

    // Address-only after AL: bus reselected, core still enabled
    run_req("len0", 4'd0, 7'h22, 1'b0, 8'd0);
    exp_q = '{12'h100, 12'h206, 12'h204, 12'h144, 12'h201, 12'h205};
    check_log("len0");
    check_eq("len0_status", last_status, 0);

    // Reset while the first data byte is on the bus
    wq = '{8'hC3, 8'h3C};
    issue_req(4'd0, 7'h22, 1'b0, 8'd2);
    t = 0;
    while (!(cyc_o && we_o && adr_o == 2'd1 && dat_o == 8'hC3) && t < 2000) begin
      @(negedge clk_i); t++;
    end
    check_eq("rst_mid_found", (t < 2000), 1);
    n0 = done_cnt;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("rst_mid_cyc", cyc_o, 0);
    check_eq("rst_mid_stb", stb_o, 0);
    @(negedge clk_i);
    check_eq("rst_mid_ready", req_ready, 0);
    rst_i = 1'b0;
    wq.delete(); irq_i = 1'b0; irq_cnt = 0; addr_phase = 1'b0;
    repeat (5) @(negedge clk_i);
    check_eq("rst_mid_nodone", done_cnt - n0, 0);
    wq = '{8'h99};
    run_req("after_rst", 4'd0, 7'h22, 1'b0, 8'd1);
    exp_q = '{12'h0C0, 12'h100, 12'h206, 12'h204, 12'h144, 12'h201, 12'h199, 12'h201, 12'h205};
    check_log("after_rst");
    check_eq("after_rst_status", last_status, 0);

`ifdef IICMB_SEQ_TIMEOUT_EN
    // irq never arrives after START: core disabled, ERR
    irq_mute = 1'b1;
    run_req("tmo", 4'd0, 7'h22, 1'b0, 8'd0);
    exp_q = '{12'h204, 12'h000};
    check_log("tmo");
    check_eq("tmo_status", last_status, 3);
    irq_mute = 1'b0; irq_cnt = 0;
    run_req("tmo_rec", 4'd0, 7'h22, 1'b0, 8'd0);
    exp_q = '{12'h0C0, 12'h100, 12'h206, 12'h204, 12'h144, 12'h201, 12'h205};
    check_log("tmo_rec");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iicmb_txn_sequencer.md
Name: iicmb_txn_sequencer

Overview:
- Wishbone master that sequences the IICMB I2C multi-bus controller (CSR/DPR/CMDR/FSMR) on behalf of one requester.
- Turns one request (bus, 7-bit address, op, length, byte stream) into the full register-level command sequence: enable, set bus, start, address, data, stop.
- Waits on irq, decodes CMDR status, and returns read bytes and a completion code.
- Replaces hand-written register sequences in the test flow; sits between stimulus/agents and the DUT Wishbone port.

Parameters:
- NUM_BUSSES, 1, number of I2C busses behind the controller; req_bus range is 0..NUM_BUSSES-1.
- LEN_W, 8, width of the byte-count field.
- TIMEOUT_CYCLES, 100000, irq wait limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted when valid&ready
- req_bus  in  4  target bus index
- req_addr  in  7  I2C slave address
- req_op  in  1  0=write, 1=read
- req_len  in  LEN_W  data byte count
- wdata_valid  in  1  write byte available
- wdata  in  8  write byte
- wdata_ready  out  1  one-cycle pulse: wdata consumed
- rdata_valid  out  1  one-cycle pulse, no backpressure
- rdata  out  8  read byte
- done  out  1  one-cycle pulse at transaction end
- status  out  2  0=OK, 1=NAK, 2=ARB_LOST, 3=ERR/TIMEOUT; valid with done
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  2  register address: CSR=0, DPR=1, CMDR=2, FSMR=3
- dat_o  out  8  write data
- dat_i  in  8  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  controller interrupt, active-high

Behaviour:
- Reset:
  - All outputs 0; req_ready 0 during reset and 1 the cycle after.
  - core_en flag cleared; bus_valid cache cleared.
  - Reset mid-operation drops cyc_o/stb_o on the next edge and abandons the transaction with no done.
- Wishbone access:
  - One access at a time; cyc_o, stb_o, we_o, adr_o, dat_o held stable until ack_i.
  - All drop the cycle after ack; read data is captured on the ack cycle.
  - At least one idle cycle between accesses.
- Command-wait (CW):
  - Wait for irq_i=1, then read CMDR (this clears irq).
  - Decode bit7 DON, bit6 NAK, bit5 AL, bit4 ERR; the highest-priority set bit wins, order AL > ERR > NAK > DON.
- State machine:
  - IDLE: req_ready=1; on accept, latch the request and go to ENABLE if !core_en, else BUS_CHK.
  - ENABLE: write CSR=0xC0 (E|IE); set core_en.
  - BUS_CHK: if bus_valid and req_bus==cached bus, go to START. Else write DPR=req_bus, write CMDR=0x06, CW, update the cache, then START.
  - START: write CMDR=0x04, CW.
  - ADDR: write DPR={req_addr,req_op}, write CMDR=0x01, CW; NAK goes to STOP with status NAK.
  - WDATA (write, remaining>0): wait wdata_valid; pulse wdata_ready; write DPR=wdata, CMDR=0x01, CW; NAK goes to STOP with status NAK.
  - RDATA (read, remaining>0): write CMDR=0x02 (ACK), or 0x03 (NAK) for the last byte; CW; read DPR; pulse rdata_valid with rdata.
  - STOP: write CMDR=0x05, CW, then DONE.
  - DONE: pulse done and status for 1 cycle, return to IDLE; req_ready rises the next cycle.
- Status handling:
  - AL: skip STOP, clear bus_valid, status=2.
  - ERR: skip STOP, clear core_en and bus_valid, status=3.
- Length rules:
  - req_len=0 gives an address-only transaction (START, ADDR, STOP).
  - The remaining counter is LEN_W wide and decrements once per byte; it never wraps.
- Out-of-range bus: req_bus ≥ NUM_BUSSES completes immediately with done and status=3, with no Wishbone traffic.

Optional Feature:
- IICMB_SEQ_TIMEOUT_EN
- Defined: a counter runs during every CW.
  - Reaching TIMEOUT_CYCLES aborts the transaction.
  - The sequencer writes CSR=0x00, clears core_en and bus_valid, then DONE with status=3.
- Undefined: no counter; CW waits forever.

Decomposition:
- Package iicmb_seq_pkg:
  - register address constants;
  - CMDR command codes (SET_BUS, START, WRITE, READ_ACK, READ_NAK, STOP);
  - status bit positions;
  - seq_status_t enum;
  - seq_state_t enum.
- One sub-module, iicmb_wb_access: single-transfer Wishbone master. Handshake is start/we/adr/wdata in; busy/done/rdata out.

Test Plan:
- Write bus 0, addr 0x22, len 2, data 05,1F after reset:
  - Wishbone sequence is CSR←C0, DPR←00, CMDR←06, CMDR←04, DPR←44, CMDR←01, DPR←05, CMDR←01, DPR←1F, CMDR←01, CMDR←05.
  - status=0; slave sees WRITE 0x22 [05,1F].
- Read addr 0x22, len 3, slave returns AA,BB,CC:
  - CMDR←02, 02, 03.
  - rdata pulses AA, BB, CC in order; status=0.
- Write to absent addr 0x10, len 4:
  - Address NAK, then STOP issued.
  - No wdata_ready pulses; status=1.
- Two back-to-back writes on bus 0: second transaction contains no CSR write and no CMDR←06.
- rst_i asserted during WDATA: cyc_o=0 next cycle, no done. Next request starts with CSR←C0.
- With IICMB_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50, hold irq_i=0 after START: CSR←00 issued, done with status=3.
